// File: rtl/demux4_stream_pkg.sv
// Shared constants for the 1-to-4 byte stream demultiplexer.
package demux4_stream_pkg;
  localparam int CH_NUM    = 4;
  localparam int SEL_W     = 2;
  localparam int DEF_WIDTH = 8;
  localparam int DEF_CNT_W = 8;
endpackage

// File: rtl/demux_slot.sv
// One output channel: single-entry data register, valid bit and accepted-byte counter.
module demux_slot #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             take,
  input  logic [WIDTH-1:0] din,
  output logic             ready_o,
  output logic [WIDTH-1:0] dout,
  output logic             valid_o,
  output logic [CNT_W-1:0] cnt
);
  // A full slot can still load if its consumer drains it in the same cycle.
  assign ready_o = ~valid_o | take;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout    <= '0;
      valid_o <= 1'b0;
      cnt     <= '0;
    end else if (load) begin
      dout    <= din;
      valid_o <= 1'b1;
      cnt     <= cnt + CNT_W'(1);
    end else if (valid_o && take) begin
      valid_o <= 1'b0;
    end
  end
endmodule

// File: rtl/demux4_stream.sv
// Registered 1-to-4 byte demultiplexer; each channel buffers one byte independently.
module demux4_stream
  import demux4_stream_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [WIDTH-1:0]  in_data,
  input  logic [SEL_W-1:0]  in_sel,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [WIDTH-1:0]  out0,
  output logic [WIDTH-1:0]  out1,
  output logic [WIDTH-1:0]  out2,
  output logic [WIDTH-1:0]  out3,
  output logic [CH_NUM-1:0] out_valid,
  input  logic [CH_NUM-1:0] out_ready,
  output logic [CNT_W-1:0]  cnt0,
  output logic [CNT_W-1:0]  cnt1,
  output logic [CNT_W-1:0]  cnt2,
  output logic [CNT_W-1:0]  cnt3
);
  logic [CH_NUM-1:0]             load;
  logic [CH_NUM-1:0]             slot_ready;
  logic [CH_NUM-1:0]             vld;
  logic [CH_NUM-1:0][WIDTH-1:0]  data;
  logic [CH_NUM-1:0][CNT_W-1:0]  cnt;
  logic                          accept;

  // Readiness depends only on the channel the current byte targets.
  assign in_ready = slot_ready[in_sel];
  assign accept   = in_valid & in_ready;
  assign load     = accept ? (CH_NUM'(1) << in_sel) : '0;

  for (genvar k = 0; k < CH_NUM; k++) begin : g_slot
    demux_slot #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_slot (
      .clk     (clk),
      .rst_n   (rst_n),
      .load    (load[k]),
      .take    (out_ready[k]),
      .din     (in_data),
      .ready_o (slot_ready[k]),
      .dout    (data[k]),
      .valid_o (vld[k]),
      .cnt     (cnt[k])
    );
  end

  assign out_valid = vld;
  assign out0 = data[0];
  assign out1 = data[1];
  assign out2 = data[2];
  assign out3 = data[3];
  assign cnt0 = cnt[0];
  assign cnt1 = cnt[1];
  assign cnt2 = cnt[2];
  assign cnt3 = cnt[3];
endmodule
